// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Steps an address generator through a programmed list of layers. A small
//   register table holds per-layer parameters. A run walks entries
//   0..num_layers-1. For each entry it loads the fields, hands them to the
//   generator with a ready/done handshake, then waits for done to clear.
//   A saturating watchdog aborts a layer that stalls in either handshake phase.
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   cfg_we/cfg_idx/cfg_*: table write port, accepted only while idle
//   start, num_layers   : launch a run of num_layers layers (1..NUM_LAYERS)
//   ag_done / ag_ready  : handshake with the address generator
//   ag_*                : registered layer parameters for the generator
//   busy, seq_done      : run in progress / one-cycle completion pulse
//   err_tmo, err_cfg    : sticky watchdog and configuration errors
//   cur_layer           : index of the layer being processed
module layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int TMO_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfg_idx,
  input  logic [3:0]                    cfg_kernel_w,
  input  logic [7:0]                    cfg_ifm_w,
  input  logic [7:0]                    cfg_ifm_c,
  input  logic [7:0]                    cfg_ofm_w,
  input  logic [7:0]                    cfg_ofm_c,
  input  logic [1:0]                    cfg_stride,
  input  logic [31:0]                   cfg_base,
  input  logic                          start,
  input  logic [$clog2(NUM_LAYERS):0]   num_layers,
  input  logic                          ag_done,
  output logic                          ag_ready,
  output logic [3:0]                    ag_kernel_w,
  output logic [7:0]                    ag_ifm_w,
  output logic [7:0]                    ag_ifm_c,
  output logic [7:0]                    ag_ofm_w,
  output logic [7:0]                    ag_ofm_c,
  output logic [1:0]                    ag_stride,
  output logic [31:0]                   ag_addr_in,
  output logic                          busy,
  output logic                          seq_done,
  output logic                          err_tmo,
  output logic                          err_cfg,
  output logic [$clog2(NUM_LAYERS)-1:0] cur_layer
);

  localparam int IW = $clog2(NUM_LAYERS);
  localparam int CW = 70;  // packed width of one table entry

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [IW:0]      NL_MAX  = (IW+1)'(NUM_LAYERS);
  localparam logic [IW:0]      NL_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  // The cycle that carries the counter into its final value is the one that
  // trips the watchdog, so compare against the value just below all-ones.
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] WD_ONE  = TMO_W'(1);

  logic [2:0]       state, state_next;
  logic [TMO_W-1:0] wd;
  logic [IW:0]      run_len;
  logic [CW-1:0]    ag_word;
  logic [CW-1:0]    wr_word;
  logic [CW-1:0]    cfg_table [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] wr_sel;
  logic             start_ok;
  logic             last_layer;
  logic             tmo_hit;

  assign wr_word = {cfg_kernel_w, cfg_ifm_w, cfg_ifm_c, cfg_ofm_w,
                    cfg_ofm_c, cfg_stride, cfg_base};
  assign {ag_kernel_w, ag_ifm_w, ag_ifm_c, ag_ofm_w,
          ag_ofm_c, ag_stride, ag_addr_in} = ag_word;

  // Writes are only honoured while no run is active.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = cfg_we && !busy && (cfg_idx == IW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (rst) begin
        cfg_table[i] <= '0;
      end else if (wr_sel[i]) begin
        cfg_table[i] <= wr_word;
      end
    end
  end

  assign start_ok   = (num_layers != '0) && (num_layers <= NL_MAX);
  assign last_layer = ({1'b0, cur_layer} == (run_len - NL_ONE));
  // Watchdog only fires when the phase's exit condition is still unmet.
  assign tmo_hit    = (wd == WD_LAST) &&
                      (((state == S_RUN) && !ag_done) ||
                       ((state == S_RELEASE) && ag_done));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start && start_ok) state_next = S_LOAD;
      S_LOAD:    state_next = S_ISSUE;
      S_ISSUE:   state_next = S_RUN;
      S_RUN: begin
        if (ag_done)      state_next = S_RELEASE;
        else if (tmo_hit) state_next = S_IDLE;
      end
      S_RELEASE: begin
        if (!ag_done)     state_next = last_layer ? S_FINISH : S_LOAD;
        else if (tmo_hit) state_next = S_IDLE;
      end
      S_FINISH:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wd        <= '0;
      run_len   <= '0;
      ag_word   <= '0;
      ag_ready  <= 1'b0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
      err_tmo   <= 1'b0;
      err_cfg   <= 1'b0;
      cur_layer <= '0;
    end else begin
      state    <= state_next;
      // Status outputs are registered from the state being entered so they
      // line up with the state they describe.
      ag_ready <= (state_next == S_ISSUE) || (state_next == S_RUN);
      busy     <= (state_next != S_IDLE);
      seq_done <= (state_next == S_FINISH);

      if ((state == S_IDLE) && start) begin
        if (start_ok) begin
          cur_layer <= '0;
          run_len   <= num_layers;
          err_tmo   <= 1'b0;
          err_cfg   <= 1'b0;
        end else begin
          err_cfg   <= 1'b1;
        end
      end
      if (cfg_we && busy) err_cfg <= 1'b1;
      if (tmo_hit)        err_tmo <= 1'b1;

      if (state == S_LOAD) ag_word <= cfg_table[cur_layer];
      if ((state == S_RELEASE) && (state_next == S_LOAD)) begin
        cur_layer <= cur_layer + IDX_ONE;
      end

      // Restart the count on entry to RUN and to RELEASE; saturate otherwise.
      if ((state == S_ISSUE) ||
          ((state == S_RUN) && (state_next == S_RELEASE))) begin
        wd <= '0;
      end else if (((state == S_RUN) || (state == S_RELEASE)) && (wd != '1)) begin
        wd <= wd + WD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
//   Builds a cycle-by-cycle script of stimulus together with the outputs the
//   sequencer must show in each cycle. Expected outputs come from a layer
//   walk that derives each phase's length from the handshake rules. The
//   script is played into the DUT and every cycle is compared. A few
//   hand-computed literal checks pin the model itself.
module tb_layer_sequencer;

  localparam int NL = 4;
  localparam int TW = 5;
  localparam int T  = (1 << TW) - 1;  // longest stall tolerated in one phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [3:0]  cfg_kernel_w = '0;
  logic [7:0]  cfg_ifm_w = '0, cfg_ifm_c = '0, cfg_ofm_w = '0, cfg_ofm_c = '0;
  logic [1:0]  cfg_stride = '0;
  logic [31:0] cfg_base = '0;
  logic        start = 1'b0;
  logic [2:0]  num_layers = '0;
  logic        ag_done = 1'b0;
  logic        ag_ready, busy, seq_done, err_tmo, err_cfg;
  logic [3:0]  ag_kernel_w;
  logic [7:0]  ag_ifm_w, ag_ifm_c, ag_ofm_w, ag_ofm_c;
  logic [1:0]  ag_stride;
  logic [31:0] ag_addr_in;
  logic [1:0]  cur_layer;

  layer_sequencer #(.NUM_LAYERS(NL), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_w(cfg_ifm_w), .cfg_ifm_c(cfg_ifm_c),
    .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_c(cfg_ofm_c), .cfg_stride(cfg_stride),
    .cfg_base(cfg_base), .start(start), .num_layers(num_layers),
    .ag_done(ag_done), .ag_ready(ag_ready), .ag_kernel_w(ag_kernel_w),
    .ag_ifm_w(ag_ifm_w), .ag_ifm_c(ag_ifm_c), .ag_ofm_w(ag_ofm_w),
    .ag_ofm_c(ag_ofm_c), .ag_stride(ag_stride), .ag_addr_in(ag_addr_in),
    .busy(busy), .seq_done(seq_done), .err_tmo(err_tmo), .err_cfg(err_cfg),
    .cur_layer(cur_layer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we, start, done, chk;
    logic [1:0]  idx;
    logic [69:0] word;
    logic [2:0]  nl;
    logic [6:0]  ctrl;   // {ready, busy, seq_done, err_tmo, err_cfg, cur_layer}
    logic [69:0] ag;
  } rec_t;

  rec_t        q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc_n = 0;

  // Model of what the outputs show in the cycle currently being scripted.
  logic        mo_ready = 0, mo_busy = 0, mo_sdone = 0, mo_etmo = 0, mo_ecfg = 0;
  logic [1:0]  mo_cur = '0;
  logic [69:0] mo_ag = '0;
  logic [69:0] mtab [NL];

  // Observations of the DUT taken while the script plays.
  logic [31:0] addr_log[$];
  int          len_log[$];
  int          sd_cnt = 0;
  int          win_len = 0;
  logic        prev_ready = 1'b0;

  function automatic logic [69:0] rand_word();
    logic [69:0] w;
    w[31:0]  = $urandom();
    w[63:32] = $urandom();
    w[69:64] = 6'($urandom());
    return w;
  endfunction

  function automatic logic [69:0] mk_word(input logic [3:0] k, input logic [7:0] iw,
      input logic [7:0] ic, input logic [7:0] ow, input logic [7:0] oc,
      input logic [1:0] s, input logic [31:0] base);
    return {k, iw, ic, ow, oc, s, base};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_rec(input logic r_i, input logic we_i, input logic [1:0] idx_i,
      input logic [69:0] w_i, input logic st_i, input logic [2:0] nl_i,
      input logic dn_i, input logic chk_i);
    rec_t r;
    r.rst = r_i; r.we = we_i; r.idx = idx_i; r.word = w_i; r.start = st_i;
    r.nl = nl_i; r.done = dn_i; r.chk = chk_i;
    r.ctrl = {mo_ready, mo_busy, mo_sdone, mo_etmo, mo_ecfg, mo_cur};
    r.ag = mo_ag;
    q.push_back(r);
  endtask

  task automatic model_reset();
    mo_ready = 0; mo_busy = 0; mo_sdone = 0; mo_etmo = 0; mo_ecfg = 0;
    mo_cur = '0; mo_ag = '0;
    for (int i = 0; i < NL; i++) mtab[i] = '0;
  endtask

  // A cycle inside a run: start and num_layers are noise that must be ignored.
  task automatic busy_cyc(input logic dn);
    push_rec(0, 0, 2'($urandom()), rand_word(), 1'($urandom()), 3'($urandom()), dn, 1);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++)
      push_rec(0, 0, 2'($urandom()), rand_word(), 0, 3'($urandom()), 1'($urandom()), 1);
  endtask

  task automatic gen_reset(input int n, input logic first);
    for (int i = 0; i < n; i++) begin
      push_rec(1, 0, '0, '0, 0, '0, 0, !(first && i == 0));
      model_reset();
    end
  endtask

  task automatic gen_write(input logic [1:0] idx, input logic [69:0] w);
    push_rec(0, 1, idx, w, 0, 3'($urandom()), 0, 1);
    mtab[idx] = w;
  endtask

  task automatic gen_bad_start(input logic [2:0] nl);
    push_rec(0, 0, '0, '0, 1, nl, 0, 1);
    mo_ecfg = 1;
  endtask

  // One run of n layers. a[i]: RUN cycles with done low before done rises.
  // b[i]: RELEASE cycles with done still high. rst_layer: layer whose second
  // RUN cycle carries a reset (-1 for none). bad_we: table write in RUN.
  task automatic gen_run(input int n, input int a [4], input int b [4],
      input bit bad_we, input int rst_layer);
    logic dn;
    push_rec(0, 0, '0, '0, 1, 3'(n), 1'($urandom()), 1);
    mo_busy = 1; mo_cur = '0; mo_etmo = 0; mo_ecfg = 0;
    for (int i = 0; i < n; i++) begin
      busy_cyc(1'($urandom()));                 // load
      mo_ag = mtab[i]; mo_ready = 1;
      busy_cyc(1'($urandom()));                 // issue
      for (int j = 1; ; j++) begin              // run
        dn = (j > a[i]);
        if (i == rst_layer && j == 2) begin
          push_rec(1, 0, '0, '0, 0, '0, dn, 1);
          model_reset();
          return;
        end
        if (bad_we && i == 0 && j == 1) begin
          push_rec(0, 1, 2'd0, rand_word(), 0, 3'($urandom()), dn, 1);
          mo_ecfg = 1;
        end else begin
          busy_cyc(dn);
        end
        if (dn) begin mo_ready = 0; break; end
        if (j == T) begin mo_ready = 0; mo_busy = 0; mo_etmo = 1; return; end
      end
      for (int j = 1; ; j++) begin              // release
        dn = (j <= b[i]);
        busy_cyc(dn);
        if (!dn) begin
          if (i == n - 1) mo_sdone = 1;
          else mo_cur = 2'(i + 1);
          break;
        end
        if (j == T) begin mo_busy = 0; mo_etmo = 1; return; end
      end
    end
    busy_cyc(1'($urandom()));                   // finish
    mo_sdone = 0; mo_busy = 0;
  endtask

  task automatic execute();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      if (r.chk) begin
        n_assert++;
        if ({ag_ready, busy, seq_done, err_tmo, err_cfg, cur_layer} !== r.ctrl) begin
          n_fail++;
          $display("FAIL cycle%0d ctrl{ready,busy,seq_done,err_tmo,err_cfg,cur} actual=%b required=%b",
                   cyc_n, {ag_ready, busy, seq_done, err_tmo, err_cfg, cur_layer}, r.ctrl);
        end
        n_assert++;
        if ({ag_kernel_w, ag_ifm_w, ag_ifm_c, ag_ofm_w, ag_ofm_c, ag_stride, ag_addr_in} !== r.ag) begin
          n_fail++;
          $display("FAIL cycle%0d ag_fields actual=%h required=%h", cyc_n,
                   {ag_kernel_w, ag_ifm_w, ag_ifm_c, ag_ofm_w, ag_ofm_c, ag_stride, ag_addr_in}, r.ag);
        end
      end
      if (ag_ready === 1'b1 && prev_ready !== 1'b1) begin
        addr_log.push_back(ag_addr_in);
        win_len = 0;
      end
      if (ag_ready === 1'b1) win_len++;
      if (ag_ready !== 1'b1 && prev_ready === 1'b1) len_log.push_back(win_len);
      if (seq_done === 1'b1) sd_cnt++;
      prev_ready = ag_ready;
      rst = r.rst; cfg_we = r.we; cfg_idx = r.idx; start = r.start;
      num_layers = r.nl; ag_done = r.done;
      {cfg_kernel_w, cfg_ifm_w, cfg_ifm_c, cfg_ofm_w, cfg_ofm_c, cfg_stride, cfg_base} = r.word;
      cyc_n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a [4];
    int b [4];
    int sd0;
    logic [69:0] w0, w1;
    model_reset();

    // Reset values.
    gen_reset(3, 1);
    gen_idle(2);
    execute();
    chk("reset_busy", busy, 0);
    chk("reset_ready", ag_ready, 0);
    chk("reset_err_cfg", err_cfg, 0);

    // Two-layer run, done 20 cycles after ready, dropped 1 cycle after ready falls.
    w0 = mk_word(4'd3, 8'd8, 8'd4, 8'd6, 8'd4, 2'd1, 32'h100);
    w1 = mk_word(4'd3, 8'd8, 8'd4, 8'd6, 8'd4, 2'd1, 32'h400);
    gen_write(2'd0, w0);
    gen_write(2'd1, w1);
    gen_idle(1);
    addr_log.delete(); len_log.delete(); sd_cnt = 0;
    gen_run(2, '{19, 19, 0, 0}, '{1, 1, 0, 0}, 0, -1);
    gen_idle(3);
    execute();
    chk("two_layer_windows", 70'(addr_log.size()), 70'(2));
    if (addr_log.size() == 2) begin
      chk("two_layer_addr0", addr_log[0], 32'h100);
      chk("two_layer_addr1", addr_log[1], 32'h400);
    end
    if (len_log.size() >= 1) chk("ready_window_len", 70'(len_log[0]), 70'(21));
    chk("seq_done_pulses", 70'(sd_cnt), 70'(1));
    chk("busy_after_done", busy, 0);

    // Illegal start.
    addr_log.delete();
    gen_bad_start(3'd0);
    gen_idle(3);
    execute();
    chk("bad_start_err_cfg", err_cfg, 1);
    chk("bad_start_busy", busy, 0);
    chk("bad_start_no_ready", 70'(addr_log.size()), 70'(0));

    // Table write during RUN is rejected.
    gen_run(1, '{5, 0, 0, 0}, '{0, 0, 0, 0}, 1, -1);
    gen_idle(2);
    execute();
    chk("busy_write_err_cfg", err_cfg, 1);
    addr_log.delete();
    gen_run(1, '{2, 0, 0, 0}, '{0, 0, 0, 0}, 0, -1);
    gen_idle(2);
    execute();
    if (addr_log.size() >= 1) chk("busy_write_readback", addr_log[0], 32'h100);
    else chk("busy_write_readback", 70'(addr_log.size()), 70'(1));

    // Watchdog in RUN.
    len_log.delete(); sd0 = sd_cnt;
    gen_run(1, '{100, 0, 0, 0}, '{0, 0, 0, 0}, 0, -1);
    gen_idle(3);
    execute();
    chk("tmo_err", err_tmo, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_ready", ag_ready, 0);
    chk("tmo_no_seq_done", 70'(sd_cnt), 70'(sd0));
    if (len_log.size() >= 1) chk("tmo_window_len", 70'(len_log[0]), 70'(T + 1));

    // Reset in RUN of layer 1, then a fresh run from layer 0.
    gen_write(2'd2, rand_word());
    gen_run(3, '{3, 10, 3, 0}, '{1, 1, 1, 0}, 0, 1);
    gen_idle(2);
    execute();
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_cur", cur_layer, 0);
    chk("midrun_rst_addr", ag_addr_in, 0);
    gen_write(2'd0, w1);
    gen_write(2'd1, w0);
    gen_write(2'd2, rand_word());
    gen_run(2, '{4, 4, 0, 0}, '{0, 0, 0, 0}, 0, -1);
    gen_idle(2);
    // done stuck high across layers, drops after 3 release cycles
    gen_run(3, '{0, 0, 0, 0}, '{3, 3, 3, 0}, 0, -1);
    gen_idle(2);
    execute();

    // Randomised runs.
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) gen_write(2'($urandom()), rand_word());
      if ($urandom_range(0, 4) == 0) begin
        int pick;
        pick = $urandom_range(0, 3);
        gen_bad_start(pick == 0 ? 3'd0 : 3'(4 + pick));
      end
      for (int k = 0; k < 4; k++) begin
        a[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 40) : $urandom_range(0, 12);
        b[k] = ($urandom_range(0, 14) == 0) ? 35 : $urandom_range(0, 5);
      end
      gen_run($urandom_range(1, 4), a, b, ($urandom_range(0, 5) == 0), -1);
      gen_idle($urandom_range(0, 3));
    end
    execute();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
